// File: rtl/census_pkg.sv
// rtl/census_pkg.sv - shared census-transform constants and bit-index mapping
// Purpose : constants shared by the census generator and the disparity
//           correlator, plus the (row, col) -> bit-vector index mapping.
// Ports   : none (package).
package census_pkg;

   localparam int WIN      = 9;                      // square window side
   localparam int HALF     = WIN / 2;                // centre row/column
   localparam int BV_LEN   = WIN * (WIN - 1);        // 72-bit census vector
   localparam int BV_IDX_W = $clog2(BV_LEN);         // index width into bitvec
   localparam int COORD_W  = 10;                     // pixel coordinate width
   localparam int PIX_W    = 8;                      // pixel intensity width
   localparam int LB_W     = PIX_W * (WIN - 1);      // line-buffer word: 8 older lines

   // Row HALF is dropped from the vector, so rows below it shift up by one.
   // Row 0 is the oldest line, column 0 the oldest column.
   function automatic logic [BV_IDX_W-1:0] bit_index(input int row, input int col);
      int rr;
      rr = (row < HALF) ? row : row - 1;
      return BV_IDX_W'(rr * WIN + col);
   endfunction

endpackage

// File: rtl/census_line_buffer.sv
// rtl/census_line_buffer.sv - column line buffer, read-modify-write RAM wrapper
// Purpose : holds, for each image column, the previous WIN-1 lines of pixels.
//           Read data is registered; a write lands on the following edge.
// Ports   : clk_i      - clock
//           rd_en_i    - capture mem[rd_addr_i] into rd_data_o
//           rd_addr_i  - read column address
//           rd_data_o  - registered read data
//           wr_en_i    - write enable
//           wr_addr_i  - write column address
//           wr_data_i  - write data
module census_line_buffer #(
   parameter int DEPTH = 640,
   parameter int AW    = 10,
   parameter int DW    = 64
) (
   input  logic          clk_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_data_q;

   // Contents are deliberately never cleared; the consumer only trusts
   // words it has fully rewritten within the current frame.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/census_transform.sv
// rtl/census_transform.sv - streaming 9x9 census-transform generator
// Purpose : consumes an 8-bit raster pixel stream and emits one 72-bit census
//           vector per interior pixel, tagged with its centre coordinates.
//           Optional macro CENSUS_DEADZONE_EN: a neighbour sets its bit only
//           when neighbour + DEADZONE < centre.
// Ports   : clk         - clock
//           reset       - synchronous, active-high
//           pix_in      - pixel intensity
//           pix_val     - pix_in valid (no backpressure)
//           frame_start - with pix_val, marks pixel (0,0)
//           bitvec      - census vector of the centre pixel
//           bitvec_val  - one-cycle strobe for bitvec/pixel_x/pixel_y
//           pixel_x     - centre column
//           pixel_y     - centre row
module census_transform
   import census_pkg::*;
#(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int DEADZONE = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PIX_W-1:0]   pix_in,
   input  logic               pix_val,
   input  logic               frame_start,
   output logic [BV_LEN-1:0]  bitvec,
   output logic               bitvec_val,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y
);

   localparam int LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
   localparam logic [COORD_W-1:0] FULL   = COORD_W'(WIN - 1);
   localparam logic [COORD_W-1:0] OFFS   = COORD_W'(HALF);

`ifdef CENSUS_DEADZONE_EN
   localparam logic [PIX_W:0] DZ = (PIX_W+1)'(DEADZONE);
`else
   // Dead-zone disabled: the compare collapses to neighbour < centre.
   localparam logic [PIX_W:0] DZ = (PIX_W+1)'(DEADZONE * 0);
`endif

   // ---------------- input counters ----------------
   logic [COORD_W-1:0] x_cnt_q, x_cnt_d;
   logic [COORD_W-1:0] y_cnt_q, y_cnt_d;
   logic [COORD_W-1:0] cur_x, cur_y;

   always_comb begin
      // frame_start relabels the pixel being accepted as (0,0)
      cur_x   = frame_start ? '0 : x_cnt_q;
      cur_y   = frame_start ? '0 : y_cnt_q;
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      if (pix_val) begin
         if (cur_x == X_LAST) begin
            x_cnt_d = '0;
            y_cnt_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
         end else begin
            x_cnt_d = cur_x + 1'b1;
            y_cnt_d = cur_y;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_cnt_q <= '0;
         y_cnt_q <= '0;
      end else begin
         x_cnt_q <= x_cnt_d;
         y_cnt_q <= y_cnt_d;
      end
   end

   // ---------------- S0: sample pixel, issue line-buffer read ----------------
   logic               s0_val_q;
   logic               s0_ok_q;
   logic [PIX_W-1:0]   pix_d_q;
   logic [COORD_W-1:0] x_d_q, y_d_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_val_q <= 1'b0;
      end else begin
         s0_val_q <= pix_val;
      end
   end

   always_ff @(posedge clk) begin
      if (pix_val) begin
         pix_d_q <= pix_in;
         x_d_q   <= cur_x;
         y_d_q   <= cur_y;
         // Only a window made entirely of this frame's pixels is reported;
         // this also makes stale RAM words after reset/restart harmless.
         s0_ok_q <= (cur_x >= FULL) && (cur_y >= FULL);
      end
   end

   logic [LB_W-1:0] lb_rd_data;
   logic [LB_W-1:0] lb_wr_data;

   // Oldest line sits in the top byte; the new pixel enters the bottom byte.
   assign lb_wr_data = {lb_rd_data[LB_W-PIX_W-1:0], pix_d_q};

   census_line_buffer #(
      .DEPTH (IMG_W),
      .AW    (LB_AW),
      .DW    (LB_W)
   ) u_line_buffer (
      .clk_i     (clk),
      .rd_en_i   (pix_val),
      .rd_addr_i (cur_x[LB_AW-1:0]),
      .rd_data_o (lb_rd_data),
      .wr_en_i   (s0_val_q),
      .wr_addr_i (x_d_q[LB_AW-1:0]),
      .wr_data_i (lb_wr_data)
   );

   // ---------------- S1: column assembly and window shift ----------------
   logic [PIX_W-1:0]   col [WIN];
   logic [PIX_W-1:0]   win_q [WIN][WIN];
   logic               s1_val_q;
   logic [COORD_W-1:0] s1_x_q, s1_y_q;

   always_comb begin
      for (int r = 0; r < WIN - 1; r++) begin
         col[r] = lb_rd_data[LB_W-1-PIX_W*r -: PIX_W];
      end
      col[WIN-1] = pix_d_q;
   end

   always_ff @(posedge clk) begin
      if (s0_val_q) begin
         for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
            win_q[r][WIN-1] <= col[r];
         end
         s1_x_q <= x_d_q - OFFS;
         s1_y_q <= y_d_q - OFFS;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_val_q <= 1'b0;
      end else begin
         s1_val_q <= s0_val_q & s0_ok_q;
      end
   end

   // ---------------- S2: census compare ----------------
   logic [BV_LEN-1:0]  cen_d, cen_q;
   logic [PIX_W-1:0]   centre;
   logic               s2_val_q;
   logic [COORD_W-1:0] s2_x_q, s2_y_q;

   always_comb begin
      cen_d  = '0;
      centre = win_q[HALF][HALF];
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            if (r != HALF) begin
               // 9-bit add so neighbour + DZ cannot wrap
               cen_d[bit_index(r, c)] = (({1'b0, win_q[r][c]} + DZ) < {1'b0, centre});
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_val_q <= 1'b0;
         cen_q    <= '0;
         s2_x_q   <= '0;
         s2_y_q   <= '0;
      end else begin
         s2_val_q <= s1_val_q;
         if (s1_val_q) begin
            cen_q  <= cen_d;
            s2_x_q <= s1_x_q;
            s2_y_q <= s1_y_q;
         end
      end
   end

   // ---------------- S3: output register ----------------
   logic [BV_LEN-1:0]  bitvec_q;
   logic               bitvec_val_q;
   logic [COORD_W-1:0] pixel_x_q, pixel_y_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         bitvec_q     <= '0;
         bitvec_val_q <= 1'b0;
         pixel_x_q    <= '0;
         pixel_y_q    <= '0;
      end else begin
         bitvec_val_q <= s2_val_q;
         if (s2_val_q) begin
            bitvec_q  <= cen_q;
            pixel_x_q <= s2_x_q;
            pixel_y_q <= s2_y_q;
         end
      end
   end

   assign bitvec     = bitvec_q;
   assign bitvec_val = bitvec_val_q;
   assign pixel_x    = pixel_x_q;
   assign pixel_y    = pixel_y_q;

endmodule

// File: tb/tb_census_transform.sv
// tb/tb_census_transform.sv - directed self-checking bench for census_transform
module tb_census_transform;

   localparam int W = 16;
   localparam int H = 12;
   localparam int NOUT = (W - 8) * (H - 8);

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pix_in;
   logic        pix_val;
   logic        frame_start;
   logic [71:0] bitvec;
   logic        bitvec_val;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;

   always #5 clk = ~clk;

   census_transform #(
      .IMG_W    (W),
      .IMG_H    (H),
      .DEADZONE (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_in      (pix_in),
      .pix_val     (pix_val),
      .frame_start (frame_start),
      .bitvec      (bitvec),
      .bitvec_val  (bitvec_val),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [71:0] q_bv [$];
   int          q_x  [$];
   int          q_y  [$];
   int          q_t  [$];
   int          b2b;
   logic        prev_val = 1'b0;

   always @(negedge clk) begin
      if (bitvec_val === 1'b1) begin
         q_bv.push_back(bitvec);
         q_x.push_back(int'(pixel_x));
         q_y.push_back(int'(pixel_y));
         q_t.push_back(cyc);
         if (prev_val) b2b++;
      end
      prev_val = (bitvec_val === 1'b1);
   end

   function automatic logic [7:0] pix_of(input int mode, input int x, input int y);
      case (mode)
         0: return 8'd100;
         1: return 8'(x * 10);
         2: return (x == 8 && y == 6) ? 8'd10 : 8'd50;
         3: return (x == 8 && y == 6) ? 8'd200 : 8'd50;
         4: return 8'(x * 3);
         default: return 8'(x * 5);
      endcase
   endfunction

   function automatic logic [71:0] groups(input logic [8:0] g);
      logic [71:0] v;
      v = '0;
      for (int r = 0; r < 8; r++) v = v | (72'(g) << (9 * r));
      return v;
   endfunction

   task automatic clear_q();
      q_bv.delete(); q_x.delete(); q_y.delete(); q_t.delete();
      b2b = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_pixels(input int mode, input int npix, input bit fs, input bit gap,
                               output int t0);
      t0 = 0;
      for (int i = 0; i < npix; i++) begin
         @(posedge clk); #1;
         if (i == 0) t0 = cyc;
         pix_val     = 1'b1;
         pix_in      = pix_of(mode, i % W, (i / W) % H);
         frame_start = fs && (i == 0);
         if (gap) begin
            @(posedge clk); #1;
            pix_val     = 1'b0;
            frame_start = 1'b0;
         end
      end
      @(posedge clk); #1;
      pix_val     = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (bitvec_val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %0b expected 0", bitvec_val); end
      n_checks++; if (bitvec !== 72'd0) begin n_fail++; $display("FAIL reset_bitvec: got %h expected 0", bitvec); end
      n_checks++; if (pixel_x !== 10'd0) begin n_fail++; $display("FAIL reset_x: got %0d expected 0", pixel_x); end
      n_checks++; if (pixel_y !== 10'd0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", pixel_y); end
   endtask

   task automatic test_flat(input string tag);
      int t0;
      clear_q();
      drive_pixels(0, W * H, 1'b1, 1'b0, t0);
      idle(8);
      n_checks++; if (q_bv.size() != NOUT) begin n_fail++; $display("FAIL %s_count: got %0d expected %0d", tag, q_bv.size(), NOUT); end
      if (q_bv.size() > 0) begin
         n_checks++; if (q_x[0] != 4 || q_y[0] != 4) begin n_fail++; $display("FAIL %s_first: got (%0d,%0d) expected (4,4)", tag, q_x[0], q_y[0]); end
         n_checks++; if (q_t[0] != t0 + 140) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", tag, q_t[0] - t0, 140); end
         n_checks++; if (q_x[$] != 11 || q_y[$] != 7) begin n_fail++; $display("FAIL %s_last: got (%0d,%0d) expected (11,7)", tag, q_x[$], q_y[$]); end
      end
      for (int i = 0; i < q_bv.size(); i++) begin
         n_checks++; if (q_bv[i] !== 72'd0) begin n_fail++; $display("FAIL %s_bv[%0d]: got %h expected 0", tag, i, q_bv[i]); end
      end
   endtask

   task automatic test_ramp(input bit gap);
      int t0;
      logic [71:0] exp_bv;
      exp_bv = groups(9'h00F);
      clear_q();
      drive_pixels(1, W * H, 1'b1, gap, t0);
      idle(8);
      n_checks++; if (q_bv.size() != NOUT) begin n_fail++; $display("FAIL ramp%0d_count: got %0d expected %0d", gap, q_bv.size(), NOUT); end
      n_checks++; if (b2b != (gap ? 0 : 28)) begin n_fail++; $display("FAIL ramp%0d_b2b: got %0d expected %0d", gap, b2b, gap ? 0 : 28); end
      for (int i = 0; i < q_bv.size(); i++) begin
         n_checks++;
         if (q_bv[i] !== exp_bv || q_x[i] != 4 + i % 8 || q_y[i] != 4 + i / 8) begin
            n_fail++;
            $display("FAIL ramp%0d[%0d]: got %h (%0d,%0d) expected %h (%0d,%0d)", gap, i,
                     q_bv[i], q_x[i], q_y[i], exp_bv, 4 + i % 8, 4 + i / 8);
         end
      end
   endtask

   task automatic test_single_pixel();
      int t0;
      logic [71:0] exp_lo;
      exp_lo = 72'd1 << 53;
      clear_q();
      drive_pixels(2, W * H, 1'b1, 1'b0, t0);
      idle(8);
      n_checks++; if (q_bv.size() != NOUT) begin n_fail++; $display("FAIL dark_count: got %0d expected %0d", q_bv.size(), NOUT); end
      if (q_bv.size() > 0) begin
         n_checks++; if (q_bv[0] !== exp_lo) begin n_fail++; $display("FAIL dark_bv: got %h expected %h", q_bv[0], exp_lo); end
      end
      clear_q();
      drive_pixels(3, W * H, 1'b1, 1'b0, t0);
      idle(8);
      n_checks++; if (q_bv.size() != NOUT) begin n_fail++; $display("FAIL bright_count: got %0d expected %0d", q_bv.size(), NOUT); end
      if (q_bv.size() > 20) begin
         n_checks++; if (q_x[20] != 8 || q_y[20] != 6) begin n_fail++; $display("FAIL bright_xy: got (%0d,%0d) expected (8,6)", q_x[20], q_y[20]); end
         n_checks++; if (q_bv[20] !== {72{1'b1}}) begin n_fail++; $display("FAIL bright_bv: got %h expected all ones", q_bv[20]); end
      end
   endtask

   task automatic test_frame_restart();
      int t0;
      clear_q();
      drive_pixels(1, 5 * W, 1'b1, 1'b0, t0);
      drive_pixels(0, W * H, 1'b1, 1'b0, t0);
      idle(8);
      n_checks++; if (q_bv.size() != NOUT) begin n_fail++; $display("FAIL restart_count: got %0d expected %0d", q_bv.size(), NOUT); end
      if (q_bv.size() > 0) begin
         n_checks++; if (q_t[0] != t0 + 140) begin n_fail++; $display("FAIL restart_first_time: got %0d expected %0d", q_t[0] - t0, 140); end
         n_checks++; if (q_x[0] != 4 || q_y[0] != 4) begin n_fail++; $display("FAIL restart_first_xy: got (%0d,%0d) expected (4,4)", q_x[0], q_y[0]); end
      end
      for (int i = 0; i < q_bv.size(); i++) begin
         n_checks++; if (q_bv[i] !== 72'd0) begin n_fail++; $display("FAIL restart_bv[%0d]: got %h expected 0", i, q_bv[i]); end
      end
   endtask

   task automatic test_reset_midstream();
      int t0;
      clear_q();
      drive_pixels(1, 150, 1'b1, 1'b0, t0);
      n_checks++; if (q_bv.size() != 8) begin n_fail++; $display("FAIL midreset_pre_count: got %0d expected 8", q_bv.size()); end
      pix_val = 1'b1;
      pix_in  = 8'd77;
      reset   = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (bitvec_val !== 1'b0) begin n_fail++; $display("FAIL midreset_val: got %0b expected 0", bitvec_val); end
      n_checks++; if (bitvec !== 72'd0) begin n_fail++; $display("FAIL midreset_bitvec: got %h expected 0", bitvec); end
      n_checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin n_fail++; $display("FAIL midreset_xy: got (%0d,%0d) expected (0,0)", pixel_x, pixel_y); end
      reset   = 1'b0;
      pix_val = 1'b0;
      idle(2);
      test_flat("after_reset");
   endtask

   task automatic test_back_to_back();
      int t0;
      clear_q();
      drive_pixels(0, 2 * W * H, 1'b1, 1'b0, t0);
      idle(8);
      n_checks++; if (q_bv.size() != 2 * NOUT) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", q_bv.size(), 2 * NOUT); end
      if (q_bv.size() > NOUT) begin
         n_checks++; if (q_x[NOUT] != 4 || q_y[NOUT] != 4) begin n_fail++; $display("FAIL b2b_second_xy: got (%0d,%0d) expected (4,4)", q_x[NOUT], q_y[NOUT]); end
         n_checks++; if (q_t[NOUT] != t0 + W * H + 140) begin n_fail++; $display("FAIL b2b_second_time: got %0d expected %0d", q_t[NOUT] - t0, W * H + 140); end
      end
   endtask

   task automatic test_deadzone();
      int t0;
      logic [71:0] exp3, exp5;
`ifdef CENSUS_DEADZONE_EN
      exp3 = groups(9'h007);
`else
      exp3 = groups(9'h00F);
`endif
      exp5 = groups(9'h00F);
      clear_q();
      drive_pixels(4, W * H, 1'b1, 1'b0, t0);
      idle(8);
      n_checks++; if (q_bv.size() != NOUT) begin n_fail++; $display("FAIL dz3_count: got %0d expected %0d", q_bv.size(), NOUT); end
      for (int i = 0; i < q_bv.size(); i++) begin
         n_checks++; if (q_bv[i] !== exp3) begin n_fail++; $display("FAIL dz3_bv[%0d]: got %h expected %h", i, q_bv[i], exp3); end
      end
      clear_q();
      drive_pixels(5, W * H, 1'b1, 1'b0, t0);
      idle(8);
      n_checks++; if (q_bv.size() != NOUT) begin n_fail++; $display("FAIL dz5_count: got %0d expected %0d", q_bv.size(), NOUT); end
      for (int i = 0; i < q_bv.size(); i++) begin
         n_checks++; if (q_bv[i] !== exp5) begin n_fail++; $display("FAIL dz5_bv[%0d]: got %h expected %h", i, q_bv[i], exp5); end
      end
   endtask

   initial begin
      reset       = 1'b1;
      pix_val     = 1'b0;
      frame_start = 1'b0;
      pix_in      = 8'd0;
      idle(3);
      test_reset();
      reset = 1'b0;
      idle(2);
      test_flat("flat");
      test_ramp(1'b0);
      test_ramp(1'b1);
      test_single_pixel();
      test_frame_restart();
      test_reset_midstream();
      test_back_to_back();
      test_deadzone();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
